btn_step_conditioner: RTL and testbench



---
 rtl/btn_step_conditioner.sv | 170 +++++++++++++++++
 tb/tb_btn_step_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_conditioner.sv
// Debounced push-button to single-cycle step pulses with long-press detection.
// Define BTN_AUTOREPEAT_EN to emit auto-repeat steps while the button is held.
module btn_step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 262,
  parameter int unsigned HOLD_CYCLES     = 16384,
  parameter int unsigned REPEAT_CYCLES   = 4096,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_n,
  output logic step,
  output logic held,
  output logic released
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 32'd1);
`endif

  // Terminal counts must fit the counter and repeat spacing must keep steps apart.
  localparam bit PARAMS_OK =
    (DEBOUNCE_CYCLES >= 32'd1) && (HOLD_CYCLES >= 32'd1) && (REPEAT_CYCLES >= 32'd2) &&
    ((64'd1 << CNT_W) > 64'(DEBOUNCE_CYCLES)) &&
    ((64'd1 << CNT_W) > 64'(HOLD_CYCLES)) &&
    ((64'd1 << CNT_W) > 64'(REPEAT_CYCLES));

  if (!PARAMS_OK) begin : g_param_check
    $error("btn_step_conditioner: counter too narrow or cycle counts out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HOLD_WAIT,
    ST_REPEAT,
    ST_RELEASE_DB
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;
  logic             r_step;
  logic             r_held;
  logic             r_released;
  logic             w_step_nxt;
  logic             w_held_nxt;
  logic             w_released_nxt;

  // Two-flop synchronizer; idles at 1 so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_step     <= 1'b0;
      r_held     <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_step     <= w_step_nxt;
      r_held     <= w_held_nxt;
      r_released <= w_released_nxt;
    end
  end

  // Shared counter restarts from zero on every state change.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_step_nxt     = 1'b0;
    w_released_nxt = 1'b0;
    if (!ena) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pressed) begin
            w_state_nxt = ST_PRESS_DB;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRESS_DB: begin
          if (!w_pressed) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt = ST_HOLD_WAIT;
            w_cnt_nxt   = '0;
            w_step_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD_WAIT: begin
          if (!w_pressed) begin
            w_state_nxt = ST_RELEASE_DB;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_REPEAT;
            w_cnt_nxt   = '0;
`ifdef BTN_AUTOREPEAT_EN
            w_step_nxt  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          // Without auto-repeat the counter simply stays at zero here.
          if (!w_pressed) begin
            w_state_nxt = ST_RELEASE_DB;
            w_cnt_nxt   = '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (r_cnt == RPT_LAST) begin
            w_cnt_nxt  = '0;
            w_step_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_RELEASE_DB: begin
          // A bounce back to pressed re-arms the hold timer without a new step.
          if (w_pressed) begin
            w_state_nxt = ST_HOLD_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = '0;
            w_released_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_held_nxt = (w_state_nxt == ST_REPEAT);
  end

  assign step     = r_step;
  assign held     = r_held;
  assign released = r_released;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Scoreboard bench for btn_step_conditioner: directed scenarios plus random button waveforms.
module tb_btn_step_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  localparam int W = 8;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int EV_STEP = 0;
  localparam int EV_REL  = 1;
  localparam int EV_HON  = 2;
  localparam int EV_HOFF = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ena   = 1'b0;
  logic btn_n = 1'b1;
  logic step;
  logic held;
  logic released;

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .CNT_W          (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .btn_n   (btn_n),
    .step    (step),
    .held    (held),
    .released(released)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;

  // Reference model state: synchronizer delay, accepted level, run length, hold anchor.
  bit m1 = 1'b1;
  bit m2 = 1'b1;
  bit acc = 1'b0;
  bit m_held = 1'b0;
  int run = 0;
  int anchor = 0;

  bit mon_held = 1'b0;
  bit mon_prev_step = 1'b0;
  int steps_seen = 0;
  int rels_seen = 0;
  int first_step_edge = -1;
  int last_step_edge = -1;
  int held_rise_edge = -1;
  int last_rel_edge = -1;

  function automatic string kname(input int k);
    case (k)
      EV_STEP: return "step";
      EV_REL:  return "released";
      EV_HON:  return "held_rise";
      default: return "held_fall";
    endcase
  endfunction

  // Press accepted after D+1 consecutive pressed samples, release likewise;
  // once accepted, hold/repeat timing is plain arithmetic on time since the anchor.
  function automatic void model_edge(input bit b, input bit e);
    bit p;
    bit st;
    bit rl;
    bit hd;
    int el;
    p  = !m2;
    m2 = m1;
    m1 = b;
    st = 1'b0;
    rl = 1'b0;
    hd = 1'b0;
    if (!e) begin
      acc = 1'b0;
      run = 0;
    end else if (!acc) begin
      if (p) begin
        run++;
        if (run == D + 1) begin
          acc    = 1'b1;
          run    = 0;
          anchor = edge_n;
          st     = 1'b1;
        end
      end else begin
        run = 0;
      end
    end else begin
      if (p) begin
        if (run > 0) begin
          anchor = edge_n;
          run    = 0;
        end else begin
          el = edge_n - anchor;
          hd = (el >= H);
          if (AUTO && el >= H && ((el - H) % R) == 0) st = 1'b1;
        end
      end else begin
        run++;
        if (run == D + 1) begin
          acc = 1'b0;
          run = 0;
          rl  = 1'b1;
        end
      end
    end
    if (st) sbq.push_back('{edge_n, EV_STEP});
    if (rl) sbq.push_back('{edge_n, EV_REL});
    if (hd && !m_held) sbq.push_back('{edge_n, EV_HON});
    if (!hd && m_held) sbq.push_back('{edge_n, EV_HOFF});
    m_held = hd;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_evt(input int kind);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at edge %0d, expected nothing", kname(kind), edge_n);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.cyc != edge_n) begin
        errors++;
        $display("FAIL event: got %s at edge %0d, expected %s at edge %0d",
                 kname(kind), edge_n, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: every observed output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_held      = 1'b0;
      mon_prev_step = 1'b0;
    end else begin
      if (step) begin
        check_evt(EV_STEP);
        steps_seen++;
        last_step_edge = edge_n;
        if (first_step_edge < 0) first_step_edge = edge_n;
        chk("step_back_to_back", int'(mon_prev_step), 0);
      end
      if (released) begin
        check_evt(EV_REL);
        rels_seen++;
        last_rel_edge = edge_n;
      end
      if (held && !mon_held) begin
        check_evt(EV_HON);
        if (held_rise_edge < 0) held_rise_edge = edge_n;
      end
      if (!held && mon_held) check_evt(EV_HOFF);
      mon_held      = held;
      mon_prev_step = step;
      while (sbq.size() > 0 && sbq[0].cyc <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL event: got nothing at edge %0d, expected %s at edge %0d",
                 edge_n, kname(sbq[0].kind), sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic tick(input logic b, input logic e);
    btn_n = b;
    ena   = e;
    @(posedge clk);
    edge_n++;
    model_edge(b, e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic b);
    #2;
    btn_n = b;
    ena   = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_released", int'(released), 0);
    chk("rst_pending_events", sbq.size(), 0);
    sbq.delete();
    m1 = 1'b1;
    m2 = 1'b1;
    acc = 1'b0;
    m_held = 1'b0;
    run = 0;
    anchor = 0;
    edge_n = 0;
    first_step_edge = -1;
    last_step_edge = -1;
    held_rise_edge = -1;
    last_rel_edge = -1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int r0;
    int len;
    bit lvl;
    bit en;

    // Reset released with the button already down, then a long hold.
    do_reset(1'b0);
    s0 = steps_seen;
    r0 = rels_seen;
    repeat (60) tick(1'b0, 1'b1);
    repeat (12) tick(1'b1, 1'b1);
    chk("long_first_step_edge", first_step_edge, 7);
    chk("long_held_rise_edge", held_rise_edge, 27);
    chk("long_step_count", steps_seen - s0, AUTO ? 6 : 1);
    chk("long_release_count", rels_seen - r0, 1);
    chk("long_release_edge", last_rel_edge, 67);

    // Short bounce is rejected; a following real press debounces from scratch.
    do_reset(1'b1);
    s0 = steps_seen;
    r0 = rels_seen;
    repeat (3) tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    repeat (12) tick(1'b1, 1'b1);
    chk("bounce_steps", steps_seen - s0, 0);
    chk("bounce_releases", rels_seen - r0, 0);
    repeat (10) tick(1'b0, 1'b1);
    chk("after_bounce_step_edge", first_step_edge, 25);

    // Release bounce re-arms the hold timer without a release or extra step.
    repeat (2) tick(1'b1, 1'b1);
    repeat (30) tick(1'b0, 1'b1);
    chk("rel_bounce_no_release", rels_seen - r0, 0);
    chk("rel_bounce_held_edge", held_rise_edge, 53);
    repeat (10) tick(1'b1, 1'b1);
    chk("rel_bounce_release_count", rels_seen - r0, 1);

    // ena drop in REPEAT, re-enable with button down, then reset during REPEAT.
    do_reset(1'b1);
    repeat (35) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("ena_drop_held", int'(held), 0);
    chk("ena_drop_step", int'(step), 0);
    repeat (2) tick(1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b1);
    chk("ena_rearm_step_edge", last_step_edge, 43);
    repeat (25) tick(1'b0, 1'b1);
    chk("ena_rearm_held", int'(held), 1);
    do_reset(1'b0);
    repeat (10) tick(1'b0, 1'b1);
    chk("rst_midpress_step_edge", first_step_edge, 7);
    repeat (10) tick(1'b1, 1'b1);

    // Random waveforms: alternating levels of random length, occasional ena drops and resets.
    for (int s = 0; s < 150; s++) begin
      len = int'($urandom_range(1, 34));
      lvl = 1'(s % 2);
      en  = ($urandom_range(0, 19) != 0);
      repeat (len) tick(lvl, en);
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    repeat (20) tick(1'b1, 1'b1);
    chk("final_pending_events", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
